uart_rx_axis: RTL and testbench

UART_RX_AXIS -- requirements
Module: uart_rx_axis

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_sync2.sv | 29 ++
 rtl/uart_rx_axis.sv | 157 +++++++++++++++
 tb/tb_uart_rx_axis.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive and transmit blocks.
//   UART_DATA_WIDTH  default payload bits per frame
//   UART_OVERSAMPLE  clk-cycle multiple applied to pre_scale to get one bit time
//   UART_CNT_W       width of the bit-timing counter (holds 65535*8)
//   uart_state_t     frame state machine encoding
//   uart_bit_period  bit period in clk cycles for a given pre_scale
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;
    localparam int UART_OVERSAMPLE = 8;
    localparam int UART_CNT_W      = 19;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    // A pre_scale of zero would give a zero-length bit; run it as 1 instead.
    function automatic logic [UART_CNT_W-1:0] uart_bit_period(input logic [15:0] pre_scale);
        logic [15:0] eff;
        eff = (pre_scale == 16'd0) ? 16'd1 : pre_scale;
        return UART_CNT_W'(eff) * UART_CNT_W'(UART_OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// ----------------------------------------------------------------------------
// uart_sync2
// Two-flop synchronizer for the asynchronous serial line. Both flops reset to
// 1 so the line reads as idle (high) straight out of reset.
//   clk  system clock
//   rst  asynchronous active-high reset
//   d    asynchronous input
//   q    input synchronized to clk
// ----------------------------------------------------------------------------
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_axis.sv
// ----------------------------------------------------------------------------
// uart_rx_axis
// UART receiver (start bit, DATA_WIDTH data bits LSB first, one stop bit)
// presenting each received word on an AXI-Stream style master port.
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   rxd            serial line, idle high, asynchronous to clk
//   pre_scale      bit period / 8, in clk cycles (0 is treated as 1)
//   m_axis_tdata   received word
//   m_axis_tvalid  tdata holds an unconsumed word
//   m_axis_tready  downstream accepts the word
//   busy           a frame is being received
//   frame_error    one-cycle pulse: stop bit sampled low, word dropped
//   overrun_error  one-cycle pulse: new word overwrote an unconsumed one
// ----------------------------------------------------------------------------
module uart_rx_axis
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rxd,
    input  logic [15:0]           pre_scale,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  frame_error,
    output logic                  overrun_error
);

    localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [UART_CNT_W-1:0] CNT_ONE = UART_CNT_W'(1);

    logic                  rxd_s;
    uart_state_t           state;
    logic [UART_CNT_W-1:0] cnt;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    // Set once the line has been seen high in IDLE; a start edge is only
    // accepted while armed, so a stuck-low line after a bad stop bit is not
    // mistaken for a new frame.
    logic                  line_armed;

    logic [UART_CNT_W-1:0] period;
    logic [UART_CNT_W-1:0] half_reload;
    logic [UART_CNT_W-1:0] full_reload;
    logic                  cnt_expired;
    logic                  handshake;

    uart_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxd_s)
    );

    // pre_scale is only looked at when the counter is reloaded, so a change
    // mid-frame takes effect at the next bit boundary.
    always_comb begin
        period      = uart_bit_period(pre_scale);
        half_reload = (period >> 1) - CNT_ONE;
        full_reload = period - CNT_ONE;
        cnt_expired = (cnt == '0);
        handshake   = m_axis_tvalid && m_axis_tready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            line_armed    <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            busy          <= 1'b0;
            frame_error   <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            frame_error   <= 1'b0;
            overrun_error <= 1'b0;

            // A word completing on this same edge overrides the clear below.
            if (handshake) begin
                m_axis_tvalid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!line_armed) begin
                        line_armed <= rxd_s;
                    end else if (!rxd_s) begin
                        state <= START;
                        cnt   <= half_reload;
                        busy  <= 1'b1;
                    end
                end

                START: begin
                    if (cnt_expired) begin
                        if (!rxd_s) begin
                            state   <= DATA;
                            cnt     <= full_reload;
                            bit_cnt <= '0;
                        end else begin
                            // Line went back high by mid-start-bit: a glitch.
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                DATA: begin
                    if (cnt_expired) begin
                        // LSB arrives first, so shift in from the top.
                        shift_reg <= {rxd_s, shift_reg[DATA_WIDTH-1:1]};
                        cnt       <= full_reload;
                        if (bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1)) begin
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                STOP: begin
                    if (cnt_expired) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        line_armed <= 1'b0;
                        if (rxd_s) begin
                            m_axis_tdata  <= shift_reg;
                            m_axis_tvalid <= 1'b1;
                            overrun_error <= m_axis_tvalid && !m_axis_tready;
                        end else begin
                            frame_error <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_axis.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_axis
// Directed bench for uart_rx_axis. Frames are driven by a serial transmit
// task; a negedge monitor logs accepted words and counts output pulses, and
// each scenario compares the counter deltas against hand-computed values.
// ----------------------------------------------------------------------------
module tb_uart_rx_axis;

    logic        clk;
    logic        rst;
    logic        rxd;
    logic [15:0] pre_scale;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        busy;
    logic        frame_error;
    logic        overrun_error;

    uart_rx_axis #(
        .DATA_WIDTH (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rxd           (rxd),
        .pre_scale     (pre_scale),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .busy          (busy),
        .frame_error   (frame_error),
        .overrun_error (overrun_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- monitor (sole writer of these) ----------------
    int         mon_tvalid_cyc = 0;
    int         mon_busy_cyc   = 0;
    int         mon_fe         = 0;
    int         mon_ov         = 0;
    int         rx_n           = 0;
    logic [7:0] rx_log [64];

    always @(negedge clk) begin
        if (!rst) begin
            if (m_axis_tvalid) mon_tvalid_cyc++;
            if (busy)          mon_busy_cyc++;
            if (frame_error)   mon_fe++;
            if (overrun_error) mon_ov++;
            if (m_axis_tvalid && m_axis_tready) begin
                if (rx_n < 64) rx_log[rx_n] = m_axis_tdata;
                rx_n++;
            end
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    int b_tv, b_busy, b_fe, b_ov, b_rx;

    task automatic snap();
        b_tv   = mon_tvalid_cyc;
        b_busy = mon_busy_cyc;
        b_fe   = mon_fe;
        b_ov   = mon_ov;
        b_rx   = rx_n;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Serial transmitter: start, 8 data bits LSB first, stop; p = clk per bit.
    task automatic uart_tx_frame(input logic [7:0] b, input logic stop_bit, input int p);
        rxd = 1'b0;
        tick(p);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(p);
        end
        rxd = stop_bit;
        tick(p);
        rxd = 1'b1;
    endtask

    function automatic logic [7:0] logged(input int idx);
        if (idx >= 0 && idx < 64) return rx_log[idx];
        return 8'hxx;
    endfunction

    initial begin
        rst           = 1'b1;
        rxd           = 1'b1;
        pre_scale     = 16'd1;
        m_axis_tready = 1'b1;
        tick(3);

        // reset state
        check("rst_tdata",   32'(m_axis_tdata),  32'h0);
        check("rst_tvalid",  32'(m_axis_tvalid), 32'h0);
        check("rst_busy",    32'(busy),          32'h0);
        check("rst_ferr",    32'(frame_error),   32'h0);
        check("rst_overrun", 32'(overrun_error), 32'h0);
        rst = 1'b0;
        tick(5);

        // 0xA5 at pre_scale=1 (8 clk/bit), tready high
        snap();
        uart_tx_frame(8'hA5, 1'b1, 8);
        tick(20);
        check("a5_count",    32'(rx_n - b_rx),           32'd1);
        check("a5_data",     32'(logged(b_rx)),          32'hA5);
        check("a5_tv_cyc",   32'(mon_tvalid_cyc - b_tv), 32'd1);
        check("a5_busy_seen",32'(mon_busy_cyc > b_busy), 32'd1);
        check("a5_ferr",     32'(mon_fe - b_fe),         32'd0);
        check("a5_overrun",  32'(mon_ov - b_ov),         32'd0);

        // start glitch: low for 3 clk at pre_scale=4 (32 clk/bit)
        pre_scale = 16'd4;
        tick(2);
        snap();
        rxd = 1'b0;
        tick(3);
        rxd = 1'b1;
        tick(60);
        check("gl_busy_seen",32'(mon_busy_cyc > b_busy), 32'd1);
        check("gl_count",    32'(rx_n - b_rx),           32'd0);
        check("gl_tv_cyc",   32'(mon_tvalid_cyc - b_tv), 32'd0);
        check("gl_ferr",     32'(mon_fe - b_fe),         32'd0);
        check("gl_busy_end", 32'(busy),                  32'd0);

        // 0x3C with a low stop bit at pre_scale=2 (16 clk/bit)
        pre_scale = 16'd2;
        tick(2);
        snap();
        uart_tx_frame(8'h3C, 1'b0, 16);
        tick(40);
        check("fe_pulses",   32'(mon_fe - b_fe),         32'd1);
        check("fe_tv_cyc",   32'(mon_tvalid_cyc - b_tv), 32'd0);
        check("fe_count",    32'(rx_n - b_rx),           32'd0);
        check("fe_overrun",  32'(mon_ov - b_ov),         32'd0);

        // overrun: tready low, 0x11 then 0x22 back to back at pre_scale=1
        pre_scale     = 16'd1;
        m_axis_tready = 1'b0;
        tick(2);
        snap();
        uart_tx_frame(8'h11, 1'b1, 8);
        uart_tx_frame(8'h22, 1'b1, 8);
        tick(10);
        check("ov_pulses",   32'(mon_ov - b_ov),   32'd1);
        check("ov_tdata",    32'(m_axis_tdata),    32'h22);
        check("ov_tvalid",   32'(m_axis_tvalid),   32'd1);
        check("ov_no_hs",    32'(rx_n - b_rx),     32'd0);
        m_axis_tready = 1'b1;
        tick(4);
        check("ov_hs_count", 32'(rx_n - b_rx),     32'd1);
        check("ov_hs_data",  32'(logged(b_rx)),    32'h22);
        check("ov_cleared",  32'(m_axis_tvalid),   32'd0);

        // reset after 4th data bit of 0xFF, then 0x55
        tick(2);
        snap();
        rxd = 1'b0;
        tick(8);
        rxd = 1'b1;
        tick(32);
        rst = 1'b1;
        tick(4);
        check("mid_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("mid_rst_busy",   32'(busy),          32'd0);
        rst = 1'b0;
        tick(20);
        uart_tx_frame(8'h55, 1'b1, 8);
        tick(20);
        check("mr_count",    32'(rx_n - b_rx),   32'd1);
        check("mr_data",     32'(logged(b_rx)),  32'h55);
        check("mr_ferr",     32'(mon_fe - b_fe), 32'd0);

        // pre_scale=0 runs as pre_scale=1
        pre_scale = 16'd0;
        tick(2);
        snap();
        uart_tx_frame(8'h3A, 1'b1, 8);
        tick(20);
        check("ps0_count",   32'(rx_n - b_rx),   32'd1);
        check("ps0_data",    32'(logged(b_rx)),  32'h3A);

        // loopback stream at pre_scale=3 (24 clk/bit)
        pre_scale = 16'd3;
        tick(2);
        snap();
        uart_tx_frame(8'h00, 1'b1, 24);
        uart_tx_frame(8'h55, 1'b1, 24);
        uart_tx_frame(8'hAA, 1'b1, 24);
        uart_tx_frame(8'hFF, 1'b1, 24);
        tick(30);
        check("lb_count",    32'(rx_n - b_rx),       32'd4);
        check("lb_byte0",    32'(logged(b_rx)),      32'h00);
        check("lb_byte1",    32'(logged(b_rx + 1)),  32'h55);
        check("lb_byte2",    32'(logged(b_rx + 2)),  32'hAA);
        check("lb_byte3",    32'(logged(b_rx + 3)),  32'hFF);
        check("lb_errs",     32'((mon_fe - b_fe) + (mon_ov - b_ov)), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
